// File: rtl/heroe_pkg.sv
// -----------------------------------------------------------------------------
// heroe_pkg
// Shared definitions for the HEROE game blocks: main FSM state codes,
// obstacle type markers, W_or_L result encodings, hero pose and game FSM
// state types, and the 7-segment patterns used to draw the hero.
// No ports (package).
// -----------------------------------------------------------------------------
package heroe_pkg;

    // Main state machine codes driven on `presente`
    typedef enum logic [2:0] {
        P_OFF  = 3'd0,
        P_WLCM = 3'd1,
        P_CH   = 3'd2,
        P_GAME = 3'd3,
        P_WL   = 3'd4,
        P_PA   = 3'd5
    } presente_t;

    // Obstacle type that marks the world bonus (1..15 are real obstacles)
    localparam logic [4:0] TIPO_BONO = 5'd16;

    // World index meaning every world has been cleared
    localparam logic [1:0] MUNDO_FINAL = 2'd3;

    // Result codes sent back to the generator and the main FSM
    localparam logic [1:0] WL_JUGANDO = 2'b00;
    localparam logic [1:0] WL_PIERDE  = 2'b01;
    localparam logic [1:0] WL_GANA    = 2'b10;

    // Hero segment patterns (bit0 = segment a)
    localparam logic [6:0] SEG_SUELO    = 7'h08;
    localparam logic [6:0] SEG_SALTO    = 7'h01;
    localparam logic [6:0] SEG_AGACHADO = 7'h40;
    localparam logic [6:0] SEG_PERDIO   = 7'h7F;

    // Hero pose
    typedef enum logic [1:0] {
        SUELO,
        SALTO,
        AGACHADO
    } pose_t;

    // Game progress
    typedef enum logic [1:0] {
        IDLE,
        JUGANDO,
        PERDIO,
        GANO
    } juego_t;

    // Odd types sit on the ground and must be jumped over
    function automatic logic es_obstaculo_bajo(input logic [4:0] tipo);
        return tipo[0];
    endfunction

endpackage

// File: rtl/sincronizador.sv
// -----------------------------------------------------------------------------
// sincronizador
// N_SYNC-flop synchronizer bringing a raw asynchronous button into the clk
// domain. Every stage resets to 0.
// Ports:
//   clk     in  system clock
//   rst_n   in  synchronous active-low reset
//   i_async in  raw asynchronous input
//   o_sync  out synchronized copy, N_SYNC clk cycles later
// -----------------------------------------------------------------------------
module sincronizador #(
    parameter int N_SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [N_SYNC-1:0] r_cadena;

    // Shift chain; the shift form keeps this valid for any depth including 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cadena <= '0;
        end else begin
            r_cadena <= (r_cadena << 1) | N_SYNC'(i_async);
        end
    end

    assign o_sync = r_cadena[N_SYNC-1];

endmodule

// File: rtl/detector_colision.sv
// -----------------------------------------------------------------------------
// detector_colision
// Consumer end of the HEROE obstacle stream. Tracks the hero pose from the
// buttons, keeps the obstacle types aligned with the displayed slots, and on
// every obstacle tick decides collision, bonus grab or win.
// Ports:
//   clk             in   system clock
//   rst_n           in   synchronous active-low reset
//   presente[2:0]   in   main FSM state code
//   mundo[1:0]      in   current world, 3 = all worlds cleared
//   clk_obstaculos  in   obstacle tick level (clk domain)
//   tipo_obs[4:0]   in   type of the newest slot
//   display_obs[20:0] in three 7-seg slots, [6:0] is the hero slot
//   btn_salto       in   raw jump button
//   btn_agachar     in   raw duck button
//   W_or_L[1:0]     out  00 playing, 01 lost, 10 won
//   bono_tomado     out  bonus grabbed during the current tick period
//   hero_seg[6:0]   out  hero segment pattern
// -----------------------------------------------------------------------------
module detector_colision
    import heroe_pkg::*;
#(
    parameter int SALTO_TICKS = 2,
    parameter int N_SYNC      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  presente,
    input  logic [1:0]  mundo,
    input  logic        clk_obstaculos,
    input  logic [4:0]  tipo_obs,
    input  logic [20:0] display_obs,
    input  logic        btn_salto,
    input  logic        btn_agachar,
    output logic [1:0]  W_or_L,
    output logic        bono_tomado,
    output logic [6:0]  hero_seg
);

    localparam int JW = $clog2(SALTO_TICKS + 1);

    logic            w_salto_s;
    logic            w_agachar_s;
    logic            w_tick;
    logic            w_salto_flanco;
    logic            w_occ;
    logic            w_bajo;
    logic            w_alto;
    logic            w_bono;
    logic            w_choque;
    logic            w_bono_ok;
    logic            w_en_juego;
    logic            w_evaluar;
    logic            w_unused;

    logic            r_clk_obs_d;
    logic            r_eval;
    logic [4:0]      r_tipo_q [3];
    logic            r_salto_d;
    pose_t           r_pose;
    pose_t           r_pose_tick;
    logic [JW-1:0]   r_jcnt;
    juego_t          r_juego;
    logic [1:0]      r_w_or_l;
    logic            r_bono;

    sincronizador #(.N_SYNC(N_SYNC)) u_sync_salto (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (btn_salto),
        .o_sync  (w_salto_s)
    );

    sincronizador #(.N_SYNC(N_SYNC)) u_sync_agachar (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (btn_agachar),
        .o_sync  (w_agachar_s)
    );

    // Only the hero slot matters here; the other slots are the generator's
    assign w_unused = ^display_obs[20:7];

    assign w_tick         = clk_obstaculos & ~r_clk_obs_d;
    assign w_salto_flanco = w_salto_s & ~r_salto_d;

    // Tick edge detect, one-cycle-late evaluation strobe and the type queue.
    // The queue keeps shifting even when no evaluation happens so it stays
    // aligned with the generator's slots.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_obs_d <= 1'b0;
            r_eval      <= 1'b0;
            r_tipo_q[0] <= '0;
            r_tipo_q[1] <= '0;
            r_tipo_q[2] <= '0;
        end else begin
            r_clk_obs_d <= clk_obstaculos;
            r_eval      <= w_tick;
            if (w_tick) begin
                r_tipo_q[0] <= r_tipo_q[1];
                r_tipo_q[1] <= r_tipo_q[2];
                r_tipo_q[2] <= tipo_obs;
            end
        end
    end

    // Pose FSM. r_pose_tick snapshots the pose the hero had when the tick
    // arrived, so a jump that lands on the very tick its obstacle reaches
    // slot 0 still clears it, and a jump started on a tick does not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pose      <= SUELO;
            r_pose_tick <= SUELO;
            r_jcnt      <= '0;
            r_salto_d   <= 1'b0;
        end else begin
            r_salto_d <= w_salto_s;
            if (w_tick) begin
                r_pose_tick <= r_pose;
            end
            case (r_pose)
                SUELO: begin
                    if (w_salto_flanco) begin
                        r_pose <= SALTO;
                        r_jcnt <= JW'(SALTO_TICKS);
                    end else if (w_agachar_s) begin
                        r_pose <= AGACHADO;
                    end
                end
                SALTO: begin
                    if (w_tick) begin
                        if (r_jcnt <= JW'(1)) begin
                            r_pose <= SUELO;
                            r_jcnt <= '0;
                        end else begin
                            r_jcnt <= r_jcnt - JW'(1);
                        end
                    end
                end
                AGACHADO: begin
                    if (!w_agachar_s) begin
                        r_pose <= SUELO;
                    end
                end
                default: begin
                    r_pose <= SUELO;
                end
            endcase
        end
    end

    // Slot 0 classification: lit slot is an obstacle (odd low, even high),
    // a blank slot carrying the bonus marker is the world bonus.
    assign w_occ      = |display_obs[6:0];
    assign w_bajo     = w_occ & es_obstaculo_bajo(r_tipo_q[0]);
    assign w_alto     = w_occ & ~es_obstaculo_bajo(r_tipo_q[0]) & (r_tipo_q[0] != TIPO_BONO);
    assign w_bono     = ~w_occ & (r_tipo_q[0] == TIPO_BONO);
    assign w_choque   = (w_bajo & (r_pose_tick != SALTO)) |
                        (w_alto & (r_pose_tick != AGACHADO));
    assign w_bono_ok  = w_bono & (r_pose_tick == SALTO);
    assign w_en_juego = (presente == P_GAME) || (presente == P_WL);
    assign w_evaluar  = r_eval && (r_juego == JUGANDO) && (presente == P_GAME);

    // Game FSM with registered result. A collision is checked before the
    // final world so a simultaneous loss and win resolves as a loss.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_juego  <= IDLE;
            r_w_or_l <= WL_JUGANDO;
        end else begin
            case (r_juego)
                IDLE: begin
                    r_w_or_l <= WL_JUGANDO;
                    if (presente == P_GAME) begin
                        r_juego <= JUGANDO;
                    end
                end
                JUGANDO: begin
                    if (presente != P_GAME) begin
                        r_juego  <= IDLE;
                        r_w_or_l <= WL_JUGANDO;
                    end else if (r_eval) begin
                        if (w_choque) begin
                            r_juego  <= PERDIO;
                            r_w_or_l <= WL_PIERDE;
                        end else if (mundo == MUNDO_FINAL) begin
                            r_juego  <= GANO;
                            r_w_or_l <= WL_GANA;
                        end
                    end
                end
                PERDIO, GANO: begin
                    if (!w_en_juego) begin
                        r_juego  <= IDLE;
                        r_w_or_l <= WL_JUGANDO;
                    end
                end
                default: begin
                    r_juego  <= IDLE;
                    r_w_or_l <= WL_JUGANDO;
                end
            endcase
        end
    end

    // Bonus flag: set on the grabbing evaluation, held until the next tick
    // or until the game screens are left. Setting wins over clearing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bono <= 1'b0;
        end else if (w_evaluar && w_bono_ok) begin
            r_bono <= 1'b1;
        end else if (w_tick || !w_en_juego) begin
            r_bono <= 1'b0;
        end
    end

    // Hero pattern is a pure decode of state flops; a lost game lights the
    // whole digit.
    always_comb begin
        hero_seg = SEG_SUELO;
        if (r_juego == PERDIO) begin
            hero_seg = SEG_PERDIO;
        end else begin
            case (r_pose)
                SALTO:    hero_seg = SEG_SALTO;
                AGACHADO: hero_seg = SEG_AGACHADO;
                default:  hero_seg = SEG_SUELO;
            endcase
        end
    end

    assign W_or_L      = r_w_or_l;
    assign bono_tomado = r_bono;

endmodule

// File: tb/tb_detector_colision.sv
// -----------------------------------------------------------------------------
// tb_detector_colision
// Directed testbench for detector_colision with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_detector_colision;

    logic        clk;
    logic        rst_n;
    logic [2:0]  presente;
    logic [1:0]  mundo;
    logic        clk_obstaculos;
    logic [4:0]  tipo_obs;
    logic [20:0] display_obs;
    logic        btn_salto;
    logic        btn_agachar;
    logic [1:0]  W_or_L;
    logic        bono_tomado;
    logic [6:0]  hero_seg;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] OFF  = 3'd0;
    localparam logic [2:0] GAME = 3'd3;
    localparam logic [2:0] WL   = 3'd4;
    localparam logic [2:0] PA   = 3'd5;
    localparam logic [6:0] LIT  = 7'h3F;

    detector_colision #(.SALTO_TICKS(2), .N_SYNC(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .presente       (presente),
        .mundo          (mundo),
        .clk_obstaculos (clk_obstaculos),
        .tipo_obs       (tipo_obs),
        .display_obs    (display_obs),
        .btn_salto      (btn_salto),
        .btn_agachar    (btn_agachar),
        .W_or_L         (W_or_L),
        .bono_tomado    (bono_tomado),
        .hero_seg       (hero_seg)
    );

    // 100 MHz system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and settle 1 ns past the last one
    task automatic stepClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a new slot pattern and raise the obstacle tick for one edge
    task automatic applyStimulus(input logic [4:0] tipo, input logic [20:0] disp);
        tipo_obs       = tipo;
        display_obs    = disp;
        clk_obstaculos = 1'b1;
        stepClk(1);
        clk_obstaculos = 1'b0;
    endtask

    // Single-cycle jump press, then wait for it to reach the pose FSM
    task automatic pulseSalto();
        btn_salto = 1'b1;
        stepClk(1);
        btn_salto = 1'b0;
        stepClk(4);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        presente       = OFF;
        mundo          = 2'd0;
        clk_obstaculos = 1'b0;
        tipo_obs       = 5'd0;
        display_obs    = 21'd0;
        btn_salto      = 1'b0;
        btn_agachar    = 1'b0;

        stepClk(3);
        checkOutput("rst_wl",   {30'd0, W_or_L}, 32'h0);
        checkOutput("rst_bono", {31'd0, bono_tomado}, 32'h0);
        checkOutput("rst_hero", {25'd0, hero_seg}, 32'h08);
        rst_n    = 1'b1;
        presente = GAME;
        stepClk(2);

        // Low obstacle enters at the far slot and reaches the hero on tick 3
        $display("[TB] low obstacle, hero idle");
        applyStimulus(5'd5, {LIT, 7'h00, 7'h00});
        stepClk(3);
        applyStimulus(5'd0, {7'h00, LIT, 7'h00});
        stepClk(1);
        checkOutput("low_tick2_wl", {30'd0, W_or_L}, 32'h0);
        stepClk(2);
        applyStimulus(5'd0, {7'h00, 7'h00, LIT});
        checkOutput("low_1clk_wl", {30'd0, W_or_L}, 32'h0);
        stepClk(1);
        checkOutput("low_loss_wl",   {30'd0, W_or_L}, 32'h1);
        checkOutput("low_loss_hero", {25'd0, hero_seg}, 32'h7F);
        presente = WL;
        stepClk(2);
        checkOutput("loss_hold_wl", {30'd0, W_or_L}, 32'h1);

        // Reset in the middle of a lost game with GAME still selected
        presente = GAME;
        rst_n    = 1'b0;
        stepClk(3);
        rst_n    = 1'b1;
        stepClk(1);
        checkOutput("midrst_wl",   {30'd0, W_or_L}, 32'h0);
        checkOutput("midrst_bono", {31'd0, bono_tomado}, 32'h0);
        checkOutput("midrst_hero", {25'd0, hero_seg}, 32'h08);
        stepClk(1);

        // Same obstacle, jump pressed well before the second tick
        $display("[TB] low obstacle, hero jumps");
        applyStimulus(5'd5, {LIT, 7'h00, 7'h00});
        stepClk(2);
        pulseSalto();
        checkOutput("jump_pose", {25'd0, hero_seg}, 32'h01);
        stepClk(4);
        applyStimulus(5'd0, {7'h00, LIT, 7'h00});
        stepClk(3);
        checkOutput("jump_mid_hero", {25'd0, hero_seg}, 32'h01);
        applyStimulus(5'd0, {7'h00, 7'h00, LIT});
        stepClk(1);
        checkOutput("jump_wl",   {30'd0, W_or_L}, 32'h0);
        checkOutput("jump_land", {25'd0, hero_seg}, 32'h08);
        stepClk(2);

        // High obstacle while ducking, then with the duck released early
        $display("[TB] high obstacle, hero ducks");
        btn_agachar = 1'b1;
        stepClk(4);
        checkOutput("duck_pose", {25'd0, hero_seg}, 32'h40);
        applyStimulus(5'd6, {LIT, 7'h00, 7'h00});
        stepClk(3);
        applyStimulus(5'd0, {7'h00, LIT, 7'h00});
        stepClk(3);
        applyStimulus(5'd0, {7'h00, 7'h00, LIT});
        stepClk(1);
        checkOutput("duck_wl", {30'd0, W_or_L}, 32'h0);
        stepClk(2);
        applyStimulus(5'd6, {LIT, 7'h00, 7'h00});
        stepClk(3);
        applyStimulus(5'd0, {7'h00, LIT, 7'h00});
        btn_agachar = 1'b0;
        stepClk(4);
        checkOutput("unduck_pose", {25'd0, hero_seg}, 32'h08);
        applyStimulus(5'd0, {7'h00, 7'h00, LIT});
        stepClk(1);
        checkOutput("unduck_wl", {30'd0, W_or_L}, 32'h1);
        presente = OFF;
        stepClk(1);
        checkOutput("off_wl",   {30'd0, W_or_L}, 32'h0);
        checkOutput("off_hero", {25'd0, hero_seg}, 32'h08);
        presente = GAME;
        stepClk(2);

        // Bonus marker with a blank slot, grabbed mid-jump
        $display("[TB] bonus");
        applyStimulus(5'd16, 21'd0);
        stepClk(3);
        applyStimulus(5'd0, 21'd0);
        stepClk(2);
        pulseSalto();
        applyStimulus(5'd0, 21'd0);
        checkOutput("bono_1clk", {31'd0, bono_tomado}, 32'h0);
        stepClk(1);
        checkOutput("bono_set", {31'd0, bono_tomado}, 32'h1);
        checkOutput("bono_wl",  {30'd0, W_or_L}, 32'h0);
        stepClk(3);
        checkOutput("bono_hold", {31'd0, bono_tomado}, 32'h1);
        applyStimulus(5'd0, 21'd0);
        checkOutput("bono_clear", {31'd0, bono_tomado}, 32'h0);
        stepClk(2);
        applyStimulus(5'd16, 21'd0);
        stepClk(2);
        applyStimulus(5'd0, 21'd0);
        stepClk(2);
        applyStimulus(5'd0, 21'd0);
        stepClk(1);
        checkOutput("bono_ground", {31'd0, bono_tomado}, 32'h0);
        stepClk(2);

        // Final world reached: win on the next evaluation
        $display("[TB] all worlds cleared");
        mundo = 2'd3;
        stepClk(3);
        checkOutput("win_noeval", {30'd0, W_or_L}, 32'h0);
        applyStimulus(5'd0, 21'd0);
        stepClk(1);
        checkOutput("win_wl",   {30'd0, W_or_L}, 32'h2);
        checkOutput("win_hero", {25'd0, hero_seg}, 32'h08);
        presente = WL;
        stepClk(2);
        checkOutput("win_hold", {30'd0, W_or_L}, 32'h2);
        presente = PA;
        stepClk(1);
        checkOutput("pause_wl", {30'd0, W_or_L}, 32'h0);

        // Queue an obstacle while paused, then collide with mundo==3 active
        applyStimulus(5'd5, {LIT, 7'h00, 7'h00});
        stepClk(2);
        applyStimulus(5'd0, {7'h00, LIT, 7'h00});
        presente = GAME;
        stepClk(2);
        applyStimulus(5'd0, {7'h00, 7'h00, LIT});
        stepClk(1);
        checkOutput("loss_over_win", {30'd0, W_or_L}, 32'h1);
        presente = OFF;
        mundo    = 2'd0;
        stepClk(1);
        checkOutput("final_off_wl", {30'd0, W_or_L}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
